// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NREQ requesters with round-robin arbitration.
// One operation in flight: operands latched at grant, result registered one
// cycle later and held until the consumer accepts it.
// Optional feature macro: ALU_ARB_OVF_STICKY_EN adds a sticky ADD-overflow flag
// (ovf_sticky) with a clear input (ovf_clr).
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [6*NREQ-1:0]       req_ctrl,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [WIDTH-1:0]        resp_data,
  output logic                    resp_ovf,
  output logic                    busy
`ifdef ALU_ARB_OVF_STICKY_EN
  ,
  output logic                    ovf_sticky,
  input  logic                    ovf_clr
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_ovf_q, resp_ovf_d;

  logic             found_hi_s, found_lo_s, grant_found_s;
  logic [IDW-1:0]   idx_hi_s, idx_lo_s, grant_idx_s;
  logic [5:0]       sel_ctrl_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s;
  logic [WIDTH:0]   alu_res_s;
  logic [NREQ-1:0]  req_ready_s;

  // ALU: returns {carry, result}; carry is only meaningful for ADD.
  function automatic logic [WIDTH:0] alu_compute(input logic [5:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      6'd0:    r = {1'b0, a & b};
      6'd1:    r = {1'b0, a | b};
      6'd2:    r = {1'b0, a} + {1'b0, b};
      6'd6:    r = {1'b0, a - b};
      6'd7:    r = {{WIDTH{1'b0}}, (a < b)};
      default: r = {1'b0, ~(a | b)};
    endcase
    return r;
  endfunction

  // Round-robin search: first valid at or above rr_ptr, else first valid from 0 (wrap).
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    idx_hi_s   = '0;
    idx_lo_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_hi_s && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        found_hi_s = 1'b1;
        idx_hi_s   = IDW'(i);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (!found_lo_s && req_valid[i]) begin
        found_lo_s = 1'b1;
        idx_lo_s   = IDW'(i);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
    grant_found_s = found_hi_s | found_lo_s;
    grant_idx_s   = found_hi_s ? idx_hi_s : idx_lo_s;
  end

  // Select the winner's operands and drive the one-hot accept pulse (IDLE only, masked in reset).
  always_comb begin
    sel_ctrl_s  = '0;
    sel_a_s     = '0;
    sel_b_s     = '0;
    req_ready_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_ctrl_s     = (grant_idx_s == IDW'(i)) ? req_ctrl[6*i +: 6]       : sel_ctrl_s;
      sel_a_s        = (grant_idx_s == IDW'(i)) ? req_a[WIDTH*i +: WIDTH] : sel_a_s;
      sel_b_s        = (grant_idx_s == IDW'(i)) ? req_b[WIDTH*i +: WIDTH] : sel_b_s;
      req_ready_s[i] = (state_q == ST_IDLE) && grant_found_s &&
                       (grant_idx_s == IDW'(i)) && !reset;
    end
  end

  // ALU evaluates the operands latched at grant time.
  always_comb begin
    alu_res_s = alu_compute(ctrl_q, a_q, b_q);
  end

  // Next-state logic: IDLE grants, EXEC registers the result, RESP holds until accepted.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    gid_d       = gid_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_ovf_d  = resp_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_d  = ST_EXEC;
          ctrl_d   = sel_ctrl_s;
          a_d      = sel_a_s;
          b_d      = sel_b_s;
          gid_d    = grant_idx_s;
          rr_ptr_d = (int'(grant_idx_s) == NREQ - 1) ? '0 : grant_idx_s + IDW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        resp_data_d = alu_res_s[WIDTH-1:0];
        resp_ovf_d  = (ctrl_q == 6'd2) ? alu_res_s[WIDTH] : 1'b0;
        resp_id_d   = gid_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      ctrl_q      <= 6'd0;
      a_q         <= '0;
      b_q         <= '0;
      gid_q       <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gid_q       <= gid_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_ovf_q  <= resp_ovf_d;
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_ovf   = resp_ovf_q;

`ifdef ALU_ARB_OVF_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: set on an accepted overflowing result; set beats clear.
  always_comb begin
    sticky_d = sticky_q;
    if (resp_valid && resp_ready && resp_ovf_q) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule
